// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide unit: op encodings, cycle defaults,
// FSM state type and result constants.
package mdu_pkg;

    // Operation encodings on mdu_op; 6 and 7 are reserved and behave as NOPs.
    localparam logic [2:0] MDU_MULT  = 3'd0;
    localparam logic [2:0] MDU_MULTU = 3'd1;
    localparam logic [2:0] MDU_DIV   = 3'd2;
    localparam logic [2:0] MDU_DIVU  = 3'd3;
    localparam logic [2:0] MDU_MTHI  = 3'd4;
    localparam logic [2:0] MDU_MTLO  = 3'd5;

    // Default busy lengths; the counter is sized for 1..15.
    localparam int unsigned MDU_MULT_CYCLES_DEFAULT = 5;
    localparam int unsigned MDU_DIV_CYCLES_DEFAULT  = 10;
    localparam int unsigned MDU_CNT_W               = 4;

    // A zero divisor fills LO with this bit (all ones); HI gets the dividend.
    localparam logic MDU_DIV0_LO_BIT = 1'b1;

    typedef enum logic [0:0] {
        StIdle,
        StRun
    } mdu_state_e;

    // MULT and DIV treat their operands as two's complement.
    function automatic logic mdu_is_signed(input logic [2:0] op);
        return (op == MDU_MULT) || (op == MDU_DIV);
    endfunction

endpackage

// File: rtl/mdu_divider.sv
// Combinational signed/unsigned divider. Signed division is done on magnitudes and
// the signs are reapplied, so the quotient truncates toward zero and the remainder
// follows the dividend.
module mdu_divider #(
    parameter int unsigned WIDTH = 32
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             is_signed,
    output logic [WIDTH-1:0] quot,
    output logic [WIDTH-1:0] rem,
    output logic             by_zero
);
    import mdu_pkg::*;

    logic             neg_a;
    logic             neg_b;
    logic [WIDTH-1:0] mag_a;
    logic [WIDTH-1:0] mag_b;
    logic [WIDTH-1:0] mag_q;
    logic [WIDTH-1:0] mag_r;

    // Magnitude divide, sign fix-up and zero-divisor override.
    always_comb begin
        neg_a   = is_signed & a[WIDTH-1];
        neg_b   = is_signed & b[WIDTH-1];
        mag_a   = neg_a ? -a : a;
        mag_b   = neg_b ? -b : b;
        mag_q   = '0;
        mag_r   = '0;
        quot    = '0;
        rem     = '0;
        by_zero = 1'b0;
        if (b == '0) begin
            by_zero = 1'b1;
            quot    = {WIDTH{MDU_DIV0_LO_BIT}};
            rem     = a;
        end else begin
            mag_q = mag_a / mag_b;
            mag_r = mag_a % mag_b;
            // -2^(W-1) / -1: magnitude 2^(W-1) with positive sign wraps back to
            // 0x80..0 and remainder 0, which is exactly the required overflow result.
            quot  = (neg_a ^ neg_b) ? -mag_q : mag_q;
            rem   = neg_a ? -mag_r : mag_r;
        end
    end

endmodule

// File: rtl/mdu_unit.sv
// Multi-cycle multiply/divide unit with architectural HI/LO registers. Operations
// are latched on start, counted down in RUN and written to HI/LO atomically on
// the completion edge.
module mdu_unit #(
    parameter int unsigned WIDTH       = 32,
    parameter int unsigned MULT_CYCLES = mdu_pkg::MDU_MULT_CYCLES_DEFAULT,
    parameter int unsigned DIV_CYCLES  = mdu_pkg::MDU_DIV_CYCLES_DEFAULT
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       mdu_op,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             busy,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             div_by_zero
);
    import mdu_pkg::*;

    localparam logic [MDU_CNT_W-1:0] MultLoad = MDU_CNT_W'(MULT_CYCLES);
    localparam logic [MDU_CNT_W-1:0] DivLoad  = MDU_CNT_W'(DIV_CYCLES);

    mdu_state_e           state_q, state_d;
    logic [MDU_CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]           op_q, op_d;
    logic [WIDTH-1:0]     a_q, a_d;
    logic [WIDTH-1:0]     b_q, b_d;
    logic [WIDTH-1:0]     hi_q, hi_d;
    logic [WIDTH-1:0]     lo_q, lo_d;
    logic                 dbz_q, dbz_d;

    logic                 op_signed;
    logic [2*WIDTH-1:0]   a_ext;
    logic [2*WIDTH-1:0]   b_ext;
    logic [2*WIDTH-1:0]   prod;
    logic [WIDTH-1:0]     div_quot;
    logic [WIDTH-1:0]     div_rem;
    logic                 div_zero;

    assign op_signed = mdu_is_signed(op_q);

    // Single 2W multiplier: extending both operands to 2W makes the low 2W bits of
    // the product correct for both the signed and unsigned forms.
    always_comb begin
        a_ext = {{WIDTH{op_signed & a_q[WIDTH-1]}}, a_q};
        b_ext = {{WIDTH{op_signed & b_q[WIDTH-1]}}, b_q};
        prod  = a_ext * b_ext;
    end

    mdu_divider #(
        .WIDTH (WIDTH)
    ) u_divider (
        .a         (a_q),
        .b         (b_q),
        .is_signed (op_signed),
        .quot      (div_quot),
        .rem       (div_rem),
        .by_zero   (div_zero)
    );

    // Next-state logic: accept ops in IDLE, count down and commit the result in RUN.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        a_d     = a_q;
        b_d     = b_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        dbz_d   = dbz_q;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    case (mdu_op)
                        MDU_MULT, MDU_MULTU, MDU_DIV, MDU_DIVU: begin
                            op_d    = mdu_op;
                            a_d     = A;
                            b_d     = B;
                            cnt_d   = (mdu_op == MDU_DIV || mdu_op == MDU_DIVU)
                                      ? DivLoad : MultLoad;
                            dbz_d   = 1'b0;
                            state_d = StRun;
                        end
                        MDU_MTHI: begin
                            hi_d  = A;
                            dbz_d = 1'b0;
                        end
                        MDU_MTLO: begin
                            lo_d  = A;
                            dbz_d = 1'b0;
                        end
                        default: ;
                    endcase
                end
            end
            StRun: begin
                // start is deliberately ignored here, whatever the op.
                if (cnt_q == MDU_CNT_W'(1)) begin
                    state_d = StIdle;
                    cnt_d   = '0;
                    if (op_q == MDU_MULT || op_q == MDU_MULTU) begin
                        hi_d = prod[2*WIDTH-1:WIDTH];
                        lo_d = prod[WIDTH-1:0];
                    end else begin
                        hi_d  = div_rem;
                        lo_d  = div_quot;
                        dbz_d = div_zero;
                    end
                end else begin
                    cnt_d = cnt_q - MDU_CNT_W'(1);
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State and architectural registers; reset aborts any operation in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            op_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            dbz_q   <= dbz_d;
        end
    end

    assign busy        = (state_q == StRun);
    assign hi          = hi_q;
    assign lo          = lo_q;
    assign div_by_zero = dbz_q;

endmodule
